// File: rtl/screen_draw_ctrl.sv
// Sequences the full-screen ROM plotters and muxes the selected plotter's pixel
// stream onto the VGA adapter, pairing each x/y with the colour the ROM returns a cycle later.
module screen_draw_ctrl #(
   parameter int N_SCREENS = 3,
   parameter int WIDTH     = 320,
   parameter int HEIGHT    = 240,
   parameter int COLOUR_W  = 6,
   parameter int TIMEOUT   = 80000
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            draw_req,
   input  logic [1:0]                      screen_sel,
   input  logic [9*N_SCREENS-1:0]          src_x,
   input  logic [9*N_SCREENS-1:0]          src_y,
   input  logic [COLOUR_W*N_SCREENS-1:0]   src_colour,
   input  logic [N_SCREENS-1:0]            src_done,
   output logic [N_SCREENS-1:0]            src_en,
   output logic                            src_resetn,
   output logic [8:0]                      vga_x,
   output logic [7:0]                      vga_y,
   output logic [COLOUR_W-1:0]             vga_colour,
   output logic                            vga_plot,
   output logic                            busy,
   output logic                            draw_done,
   output logic                            err
);

   localparam int          WD_W = $clog2(TIMEOUT + 1);
   localparam logic [2:0]  NS3  = 3'(N_SCREENS);
   localparam logic [8:0]  W9   = 9'(WIDTH);
   localparam logic [8:0]  H9   = 9'(HEIGHT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, DRAW, FLUSH, DONE} state_t;

   state_t                  state_q;
   logic [1:0]              sel_q;
   logic [WD_W-1:0]         wd_q;
   logic                    flush_q;
   logic [N_SCREENS-1:0]    src_en_q;
   logic                    src_resetn_q, busy_q, draw_done_q, err_q;

   logic [8:0]              cur_x, cur_y;
   logic [COLOUR_W-1:0]     cur_colour;
   logic                    cur_done;

   logic                    vld_p1_d, vld_p1_q;
   logic [8:0]              x_p1_q;
   logic [7:0]              y_p1_q;
   logic                    vga_plot_q;
   logic [8:0]              vga_x_q;
   logic [7:0]              vga_y_q;
   logic [COLOUR_W-1:0]     vga_colour_q;

   always_comb begin
      cur_x      = '0;
      cur_y      = '0;
      cur_colour = '0;
      cur_done   = 1'b0;
      for (int i = 0; i < N_SCREENS; i++) begin
         if (sel_q == 2'(i)) begin
            cur_x      = src_x[9*i +: 9];
            cur_y      = src_y[9*i +: 9];
            cur_colour = src_colour[COLOUR_W*i +: COLOUR_W];
            cur_done   = src_done[i];
         end
      end
   end

   // The done cycle carries the plotter's restarted (0,0) and is dropped.
   assign vld_p1_d = (state_q == DRAW) && !cur_done && (cur_x < W9) && (cur_y < H9);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         wd_q         <= '0;
         flush_q      <= 1'b0;
         src_en_q     <= '0;
         src_resetn_q <= 1'b0;
         busy_q       <= 1'b0;
         draw_done_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         draw_done_q  <= 1'b0;
         err_q        <= 1'b0;
         src_resetn_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (draw_req) begin
                  if ({1'b0, screen_sel} < NS3) begin
                     sel_q        <= screen_sel;
                     state_q      <= CLEAR;
                     src_resetn_q <= 1'b0;
                     src_en_q     <= '0;
                     wd_q         <= '0;
                     busy_q       <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               state_q  <= DRAW;
               src_en_q <= N_SCREENS'(1) << sel_q;
            end
            DRAW: begin
               wd_q <= wd_q + 1'b1;
               if (cur_done) begin
                  state_q  <= FLUSH;
                  src_en_q <= '0;
                  flush_q  <= 1'b0;
               end else if (wd_q == WD_LAST) begin
                  state_q  <= FLUSH;
                  src_en_q <= '0;
                  flush_q  <= 1'b0;
                  err_q    <= 1'b1;
               end
            end
            FLUSH: begin
               if (flush_q) begin
                  state_q     <= DONE;
                  draw_done_q <= 1'b1;
               end else begin
                  flush_q <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Stage 1: coordinates of the pixel presented this cycle
   always_ff @(posedge clk) begin
      x_p1_q <= cur_x;
      y_p1_q <= cur_y[7:0];
   end

   // Stage 2: join stage-1 coordinates with the ROM colour arriving now
   always_ff @(posedge clk) begin
      if (!resetn) begin
         vld_p1_q     <= 1'b0;
         vga_plot_q   <= 1'b0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
      end else begin
         vld_p1_q     <= vld_p1_d;
         vga_plot_q   <= vld_p1_q;
         vga_x_q      <= x_p1_q;
         vga_y_q      <= y_p1_q;
         vga_colour_q <= cur_colour;
      end
   end

   assign src_en     = src_en_q;
   assign src_resetn = src_resetn_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;
   assign busy       = busy_q;
   assign draw_done  = draw_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_screen_draw_ctrl.sv
// Bench for screen_draw_ctrl: behavioural ROM plotters on a reduced screen,
// expected pixels queued at each draw request and compared as they are plotted.
module tb_screen_draw_ctrl;

   localparam int NS = 3;
   localparam int W  = 32;
   localparam int H  = 24;
   localparam int N  = W * H;
   localparam int TO = 1000;
   localparam int CW = 6;

   logic                clk = 1'b0;
   logic                resetn, draw_req;
   logic [1:0]          screen_sel;
   logic [9*NS-1:0]     src_x, src_y;
   logic [CW*NS-1:0]    src_colour;
   logic [NS-1:0]       src_done;
   logic [NS-1:0]       src_en;
   logic                src_resetn;
   logic [8:0]          vga_x;
   logic [7:0]          vga_y;
   logic [CW-1:0]       vga_colour;
   logic                vga_plot, busy, draw_done, err;

   logic [8:0]          mx [NS];
   logic [8:0]          my [NS];
   logic                mdone [NS];
   logic [5:0]          mcol [NS];
   logic                hang [NS];

   logic [31:0]         sb [$];
   int                  n_checks = 0;
   int                  n_errors = 0;

   screen_draw_ctrl #(
      .N_SCREENS(NS), .WIDTH(W), .HEIGHT(H), .COLOUR_W(CW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .resetn(resetn), .draw_req(draw_req), .screen_sel(screen_sel),
      .src_x(src_x), .src_y(src_y), .src_colour(src_colour), .src_done(src_done),
      .src_en(src_en), .src_resetn(src_resetn), .vga_x(vga_x), .vga_y(vga_y),
      .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
      .draw_done(draw_done), .err(err)
   );

   always #5 clk = ~clk;

   // Plotter: walks the screen then one terminal (0,H) position, then restarts at (0,0) with done.
   always @(posedge clk) begin
      for (int i = 0; i < NS; i++) begin
         mcol[i] <= 6'((int'(my[i]) * W + int'(mx[i])) % 64);
         if (!src_resetn) begin
            mx[i] <= '0; my[i] <= '0; mdone[i] <= 1'b0;
         end else if (src_en[i]) begin
            if (my[i] == 9'(H)) begin
               mx[i] <= '0; my[i] <= '0; mdone[i] <= !hang[i];
            end else begin
               mdone[i] <= 1'b0;
               if (mx[i] == 9'(W - 1)) begin
                  mx[i] <= '0; my[i] <= my[i] + 9'd1;
               end else begin
                  mx[i] <= mx[i] + 9'd1;
               end
            end
         end
      end
   end

   always_comb begin
      src_x = '0; src_y = '0; src_colour = '0; src_done = '0;
      for (int i = 0; i < NS; i++) begin
         src_x[9*i +: 9]       = mx[i];
         src_y[9*i +: 9]       = my[i];
         src_colour[CW*i +: CW] = mcol[i];
         src_done[i]           = mdone[i];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pk(input int x, input int y);
      logic [31:0] r;
      r = '0;
      r[22:14] = 9'(x);
      r[13:6]  = 8'(y);
      r[5:0]   = 6'((y * W + x) % 64);
      return r;
   endfunction

   task automatic push_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            sb.push_back(pk(x, y));
   endtask

   // Cycle k=1 is the CLEAR cycle right after the request is accepted.
   task automatic run_draw(input logic [1:0] sel, input bit hold, input int abort_at,
                           input int exp_plots, input int exp_last, input int exp_done,
                           input int exp_err);
      int k, w, plots, first, last, err_k, en_k;
      bit en_bad, busy_bad, seen_done;
      logic [NS-1:0] oh;
      logic [31:0] e;
      oh = NS'(1) << sel;
      screen_sel = sel;
      draw_req = 1'b1;
      w = 0;
      do begin tick(); w++; end while (!busy && w < 10);
      if (!busy) begin
         check_eq("accept", 32'(busy), 1);
         return;
      end
      if (!hold) draw_req = 1'b0;
      k = 1;
      check_eq("clear_resetn", 32'(src_resetn), 0);
      check_eq("clear_en", 32'(src_en), 0);
      plots = 0; first = 0; last = 0; err_k = 0; en_k = 0;
      en_bad = 0; busy_bad = 0; seen_done = 0;
      while (k < exp_done + 50) begin
         tick();
         k++;
         if (vga_plot) begin
            plots++;
            if (first == 0) first = k;
            last = k;
            if (sb.size() == 0) begin
               check_eq("extra_plot", {9'b0, vga_x, vga_y, vga_colour}, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check_eq("pixel", {9'b0, vga_x, vga_y, vga_colour}, e);
            end
         end
         if (src_en != '0 && en_k == 0) en_k = k;
         if (src_en != '0 && src_en != oh) en_bad = 1;
         if (!busy) busy_bad = 1;
         if (err) err_k = k;
         if (abort_at > 0 && plots == abort_at) return;
         if (draw_done) begin
            seen_done = 1;
            break;
         end
      end
      check_eq("done_cycle", seen_done ? 32'(k) : 32'd0, 32'(exp_done));
      check_eq("first_plot", 32'(first), 4);
      check_eq("last_plot", 32'(last), 32'(exp_last));
      check_eq("plot_count", 32'(plots), 32'(exp_plots));
      check_eq("en_start", 32'(en_k), 2);
      check_eq("en_onehot", 32'(en_bad), 0);
      check_eq("busy_high", 32'(busy_bad), 0);
      check_eq("err_cycle", 32'(err_k), 32'(exp_err));
      check_eq("sb_empty", 32'(sb.size()), 0);
   endtask

   initial begin
      int plots, tcnt, tlast, pos;
      bit en_seen;
      resetn = 1'b0; draw_req = 1'b0; screen_sel = '0;
      for (int i = 0; i < NS; i++) hang[i] = 1'b0;
      repeat (3) tick();
      check_eq("rst_en", 32'(src_en), 0);
      check_eq("rst_src_resetn", 32'(src_resetn), 0);
      check_eq("rst_vga", {9'b0, vga_x, vga_y, vga_colour}, 0);
      check_eq("rst_flags", {28'b0, vga_plot, busy, draw_done, err}, 0);
      resetn = 1'b1;
      tick();
      check_eq("idle_src_resetn", 32'(src_resetn), 1);

      push_frame();
      run_draw(2'd0, 1'b0, 0, N, N + 3, N + 6, 0);
      tick();
      check_eq("busy_after", 32'(busy), 0);
      check_eq("done_pulse", 32'(draw_done), 0);

      push_frame();
      run_draw(2'd1, 1'b1, 0, N, N + 3, N + 6, 0);
      push_frame();
      run_draw(2'd2, 1'b1, 0, N, N + 3, N + 6, 0);
      draw_req = 1'b0;
      tick();
      tick();
      check_eq("b2b_idle", 32'(busy), 0);

      screen_sel = 2'd3; draw_req = 1'b1;
      tick();
      check_eq("badsel_err", 32'(err), 1);
      check_eq("badsel_busy", 32'(busy), 0);
      draw_req = 1'b0;
      en_seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (src_en != '0 || busy || vga_plot) en_seen = 1;
      end
      check_eq("badsel_quiet", 32'(en_seen), 0);
      check_eq("badsel_err_pulse", 32'(err), 0);

      hang[0] = 1'b1;
      tcnt = 0; tlast = 0;
      for (int p = 0; p < TO; p++) begin
         pos = p % (N + 1);
         if (pos < N) begin
            sb.push_back(pk(pos % W, pos / W));
            tcnt++;
            tlast = p + 4;
         end
      end
      run_draw(2'd0, 1'b0, 0, tcnt, tlast, TO + 4, TO + 2);
      hang[0] = 1'b0;
      tick();
      push_frame();
      run_draw(2'd0, 1'b0, 0, N, N + 3, N + 6, 0);
      tick();

      push_frame();
      run_draw(2'd1, 1'b0, 300, N, N + 3, N + 6, 0);
      resetn = 1'b0;
      tick();
      check_eq("mid_rst_plot", 32'(vga_plot), 0);
      check_eq("mid_rst_en", 32'(src_en), 0);
      check_eq("mid_rst_busy", 32'(busy), 0);
      check_eq("mid_rst_src_resetn", 32'(src_resetn), 0);
      resetn = 1'b1;
      sb.delete();
      plots = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (vga_plot || src_en != '0) plots++;
      end
      check_eq("post_rst_quiet", 32'(plots), 0);
      push_frame();
      run_draw(2'd1, 1'b0, 0, N, N + 3, N + 6, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
